// File: rtl/ladner_approx_sub_if.sv
// Valid/ready operand and result channels of the approximate subtractor.
// The slave modport is the subtractor side; the master modport is the producer/consumer side.
interface ladner_approx_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_approx;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;
    logic             out_err;

    modport slave (
        input  in_valid, in_a, in_b, in_approx, out_ready,
        output in_ready, out_valid, out_diff, out_borrow, out_err
    );

    modport master (
        output in_valid, in_a, in_b, in_approx, out_ready,
        input  in_ready, out_valid, out_diff, out_borrow, out_err
    );
endinterface

// File: rtl/ladner_approx_sub.sv
// Two-stage approximate subtractor D = A + ~B + 1.
// The low K bits use a generate-only carry approximation and the upper bits use an
// exact carry. An exact reference runs alongside so every item carries an error flag,
// and transferred erroneous items are counted in a saturating counter.
module ladner_approx_sub #(
    parameter int WIDTH = 16,
    parameter int K     = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ladner_approx_sub_if.slave   bus,
    input  logic                 clr_count,
    output logic [CNT_W-1:0]     err_count
);

    // Stage 1 state: operands, bit terms, mode and the approximate low segment
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] a1_q, a1_d;
    logic [WIDTH-1:0] b1_q, b1_d;
    logic [WIDTH-1:0] p1_q, p1_d;
    logic [WIDTH-1:0] g1_q, g1_d;
    logic [WIDTH-1:0] low1_q, low1_d;
    logic             approx1_q, approx1_d;

    // Stage 2 state: final result presented on the output channel
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] diff2_q, diff2_d;
    logic             borrow2_q, borrow2_d;
    logic             err2_q, err2_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             adv2;
    logic             in_ready_w;
    logic             in_fire;
    logic             out_fire;

    logic [WIDTH-1:0] p_in, g_in, g_shift, low_in;

    logic [WIDTH-1:0] ap_diff;
    logic             ap_borrow;
    logic             carry;
    logic [WIDTH-1:0] ex_diff;
    logic             ex_borrow;
    logic             ap_err;

    assign adv2       = ~v2_q | bus.out_ready;
    assign in_ready_w = ~v1_q | adv2;
    assign in_fire    = bus.in_valid & in_ready_w;
    assign out_fire   = v2_q & bus.out_ready;

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = v2_q;
    assign bus.out_diff   = diff2_q;
    assign bus.out_borrow = borrow2_q;
    assign bus.out_err    = err2_q;
    assign err_count      = cnt_q;

    // Stage 1 next state: form p/g, the approximate low bits (the +1 lands on bit 0 only), and load on accept
    always_comb begin
        p_in    = bus.in_a ^ ~bus.in_b;
        g_in    = bus.in_a & ~bus.in_b;
        g_shift = {g_in[WIDTH-2:0], 1'b1};
        low_in  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < K) begin
                low_in[i] = p_in[i] ^ g_shift[i];
            end
        end

        v1_d      = v1_q;
        a1_d      = a1_q;
        b1_d      = b1_q;
        p1_d      = p1_q;
        g1_d      = g1_q;
        low1_d    = low1_q;
        approx1_d = approx1_q;
        if (in_ready_w) begin
            v1_d = bus.in_valid;
            if (bus.in_valid) begin
                a1_d      = bus.in_a;
                b1_d      = bus.in_b;
                p1_d      = p_in;
                g1_d      = g_in;
                low1_d    = low_in;
                approx1_d = bus.in_approx;
            end
        end
    end

    // Stage 2 next state: finish the upper segment from carry g_(K-1), compare with the exact difference, advance when free
    always_comb begin
        carry   = 1'b1;
        ap_diff = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < K) begin
                ap_diff[i] = low1_q[i];
                if (i == K - 1) begin
                    carry = g1_q[i];
                end
            end else begin
                ap_diff[i] = p1_q[i] ^ carry;
                carry      = g1_q[i] | (p1_q[i] & carry);
            end
        end
        ap_borrow = ~carry;

        {ex_borrow, ex_diff} = {1'b0, a1_q} - {1'b0, b1_q};
        ap_err = approx1_q & ({ap_borrow, ap_diff} != {ex_borrow, ex_diff});

        v2_d      = v2_q;
        diff2_d   = diff2_q;
        borrow2_d = borrow2_q;
        err2_d    = err2_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                diff2_d   = approx1_q ? ap_diff : ex_diff;
                borrow2_d = approx1_q ? ap_borrow : ex_borrow;
                err2_d    = ap_err;
            end
        end
    end

    // Error counter next state: clear has priority over a counted transfer, and the count sticks at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (out_fire && err2_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // All pipeline and counter registers; reset empties the pipeline and zeroes the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            a1_q      <= '0;
            b1_q      <= '0;
            p1_q      <= '0;
            g1_q      <= '0;
            low1_q    <= '0;
            approx1_q <= 1'b0;
            v2_q      <= 1'b0;
            diff2_q   <= '0;
            borrow2_q <= 1'b0;
            err2_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            v1_q      <= v1_d;
            a1_q      <= a1_d;
            b1_q      <= b1_d;
            p1_q      <= p1_d;
            g1_q      <= g1_d;
            low1_q    <= low1_d;
            approx1_q <= approx1_d;
            v2_q      <= v2_d;
            diff2_q   <= diff2_d;
            borrow2_q <= borrow2_d;
            err2_q    <= err2_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ladner_approx_sub.sv
// Directed and randomised bench for ladner_approx_sub (WIDTH=16, K=8, CNT_W=2).
// A reference model fills a scoreboard queue on every input transfer; a negedge
// monitor pops and compares on every output transfer and tracks the error count.
module tb_ladner_approx_sub;

    typedef struct packed {
        logic [15:0] diff;
        logic        borrow;
        logic        err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       clr_count;
    logic [1:0] err_count;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    logic [1:0] exp_cnt = 2'd0;

    ladner_approx_sub_if #(.WIDTH(16)) bus ();

    ladner_approx_sub #(
        .WIDTH (16),
        .K     (8),
        .CNT_W (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_count (clr_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: low byte d_i = p_i ^ g_(i-1) with the +1 on bit 0, upper byte a normal add fed by g_7
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic approx);
        logic [15:0] nb, p, g, low;
        logic [8:0]  hi;
        logic [16:0] ex;
        exp_t        r;
        nb  = ~b;
        p   = a ^ nb;
        g   = a & nb;
        low = (p ^ (g << 1) ^ 16'h0001) & 16'h00FF;
        hi  = {1'b0, a[15:8]} + {1'b0, nb[15:8]} + {8'h00, g[7]};
        ex  = {1'b0, a} - {1'b0, b};
        if (approx) begin
            r.diff   = {hi[7:0], low[7:0]};
            r.borrow = ~hi[8];
            r.err    = ({r.borrow, r.diff} != ex);
        end else begin
            r.diff   = ex[15:0];
            r.borrow = ex[16];
            r.err    = 1'b0;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic timeoutFail(input string tag);
        checks++;
        errors++;
        $error("[TB] FAIL %s: wait bound expired", tag);
    endtask

    // Offer one item and hold it until the DUT accepts; returns 1ns after the accepting edge
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic approx);
        bit got = 0;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_approx = approx;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!got) timeoutFail("accept_timeout");
    endtask

    // Wait for the first result to appear and compare it with directed constants
    task automatic expectResult(input string tag, input logic [15:0] d, input logic br, input logic er);
        bit got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = 1;
                break;
            end
        end
        if (got) begin
            checkOutput({tag, "_diff"}, 32'(bus.out_diff), 32'(d));
            checkOutput({tag, "_borrow"}, 32'(bus.out_borrow), 32'(br));
            checkOutput({tag, "_err"}, 32'(bus.out_err), 32'(er));
        end else begin
            timeoutFail({tag, "_timeout"});
        end
        @(posedge clk);
        #1;
    endtask

    // Wait until the pipeline and scoreboard are both empty
    task automatic drain();
        bit got = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!bus.out_valid && sb.size() == 0) begin
                got = 1;
                break;
            end
        end
        if (!got) timeoutFail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare transferred results against the scoreboard, track the expected error count
    always @(negedge clk) begin
        exp_t e;
        bit   counted;
        if (!rst_n) begin
            exp_cnt = 2'd0;
            sb.delete();
        end else begin
            counted = 0;
            checkOutput("err_count", 32'(err_count), 32'(exp_cnt));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    timeoutFail("unexpected_output");
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_diff", 32'(bus.out_diff), 32'(e.diff));
                    checkOutput("sb_borrow", 32'(bus.out_borrow), 32'(e.borrow));
                    checkOutput("sb_err", 32'(bus.out_err), 32'(e.err));
                    counted = e.err;
                end
            end
            if (clr_count) exp_cnt = 2'd0;
            else if (counted && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_a, bus.in_b, bus.in_approx));
        end
    end

    initial begin
        logic [15:0] held;
        int sat_exp[5] = '{1, 2, 3, 3, 3};

        rst_n         = 1'b0;
        clr_count     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_approx = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
        checkOutput("rst_out_diff", 32'(bus.out_diff), 0);
        checkOutput("rst_out_borrow", 32'(bus.out_borrow), 0);
        checkOutput("rst_out_err", 32'(bus.out_err), 0);
        checkOutput("rst_err_count", 32'(err_count), 0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_in_ready", 32'(bus.in_ready), 1);

        $display("[TB] directed arithmetic cases");
        applyStimulus(16'h1234, 16'h0034, 1'b1);
        expectResult("t1", 16'h11FE, 1'b0, 1'b1);
        drain();
        checkOutput("t1_err_count", 32'(err_count), 1);
        applyStimulus(16'h1234, 16'h0034, 1'b0);
        expectResult("t2", 16'h1200, 1'b0, 1'b0);
        drain();
        checkOutput("t2_err_count", 32'(err_count), 1);
        applyStimulus(16'h0000, 16'hFFFF, 1'b1);
        expectResult("t3", 16'h0001, 1'b1, 1'b0);
        drain();

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(16'h5555, 16'h1111, 1'b1);
        applyStimulus(16'h00F0, 16'h0F00, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'h8001;
        bus.in_b      = 16'h7FFF;
        bus.in_approx = 1'b0;
        @(negedge clk);
        checkOutput("bp_in_ready", 32'(bus.in_ready), 0);
        checkOutput("bp_out_valid", 32'(bus.out_valid), 1);
        held = bus.out_diff;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("bp_in_ready_hold", 32'(bus.in_ready), 0);
            checkOutput("bp_diff_stable", 32'(bus.out_diff), 32'(held));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_drain0", 32'(bus.out_valid), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_drain1", 32'(bus.out_valid), 1);
        @(negedge clk);
        checkOutput("bp_drain2", 32'(bus.out_valid), 1);
        @(posedge clk);
        #1;
        drain();

        $display("[TB] boundary and random items");
        applyStimulus(16'hFFFF, 16'h0000, 1'b1);
        applyStimulus(16'h0000, 16'h0000, 1'b1);
        applyStimulus(16'h8000, 16'h8000, 1'b1);
        applyStimulus(16'h00FF, 16'h0001, 1'b1);
        for (int k = 0; k < 24; k++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("[TB] counter saturation and clear");
        clr_count = 1'b1;
        @(posedge clk);
        #1;
        clr_count = 1'b0;
        checkOutput("clr_idle", 32'(err_count), 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(16'h1234, 16'h0034, 1'b1);
            drain();
            checkOutput("sat_count", 32'(err_count), 32'(sat_exp[k]));
        end
        applyStimulus(16'h1234, 16'h0034, 1'b1);
        @(posedge clk);
        #1;
        clr_count = 1'b1;
        @(negedge clk);
        checkOutput("clr_same_cycle_valid", 32'(bus.out_valid), 1);
        @(posedge clk);
        #1;
        clr_count = 1'b0;
        checkOutput("clr_wins", 32'(err_count), 0);
        drain();

        $display("[TB] reset mid-stream");
        applyStimulus(16'h1234, 16'h0034, 1'b1);
        drain();
        checkOutput("pre_rst_count", 32'(err_count), 1);
        bus.out_ready = 1'b0;
        applyStimulus(16'h4321, 16'h0021, 1'b1);
        applyStimulus(16'h0F0F, 16'h00FF, 1'b1);
        checkOutput("pre_rst_in_ready", 32'(bus.in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_out_valid", 32'(bus.out_valid), 0);
        checkOutput("rst_mid_err_count", 32'(err_count), 0);
        checkOutput("rst_mid_out_diff", 32'(bus.out_diff), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(16'h2000, 16'h0001, 1'b1);
        @(negedge clk);
        checkOutput("post_rst_lat1", 32'(bus.out_valid), 0);
        @(negedge clk);
        checkOutput("post_rst_lat2", 32'(bus.out_valid), 1);
        @(posedge clk);
        #1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
